// File: rtl/mux4_reg_pkg.sv
// mux4_reg_pkg: shared datapath select encodings and default data width
package mux4_reg_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_B   = 2'd1,
    SEL_C   = 2'd2,
    SEL_D   = 2'd3
  } sel_e;
endpackage

// File: rtl/mux4_reg_if.sv
// mux4_reg_if: source buses, select code and selected output of the A-path selector
interface mux4_reg_if
  import mux4_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W
);
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] Bin;
  logic [WIDTH-1:0] Cin;
  logic [WIDTH-1:0] Din;
  logic [1:0]       reg_sel4;
  logic [WIDTH-1:0] Aout;
  modport master (output alu_out, Bin, Cin, Din, reg_sel4, input Aout);
  modport slave  (input alu_out, Bin, Cin, Din, reg_sel4, output Aout);
endinterface

// File: rtl/mux4_reg.sv
// mux4_reg: 4:1 source selector for the A register path, registered or combinational output
module mux4_reg
  import mux4_reg_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter bit REGISTERED = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mux4_reg_if.slave   bus
);
  logic [WIDTH-1:0] sel_d;
  // pick the source by select code; an unknown code yields X rather than a fallback source
  always_comb begin
    case (bus.reg_sel4)
      SEL_ALU: sel_d = bus.alu_out;
      SEL_B:   sel_d = bus.Bin;
      SEL_C:   sel_d = bus.Cin;
      SEL_D:   sel_d = bus.Din;
      default: sel_d = 'x;
    endcase
  end
  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] q;
    // load the selected source every edge, reset forces zero
    always_ff @(posedge clk) q <= rst ? '0 : sel_d;
    assign bus.Aout = q;
  end else begin : g_comb
    assign bus.Aout = sel_d;
  end
endmodule

// File: tb/tb_mux4_reg.sv
// tb_mux4_reg: directed and randomized checks of registered, combinational and 16-bit builds
module tb_mux4_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;

  mux4_reg_if #(.WIDTH(8))  m_if ();
  mux4_reg_if #(.WIDTH(8))  c_if ();
  mux4_reg_if #(.WIDTH(16)) w_if ();

  mux4_reg #(.WIDTH(8),  .REGISTERED(1'b1)) u_reg  (.clk(clk), .rst(rst), .bus(m_if.slave));
  mux4_reg #(.WIDTH(8),  .REGISTERED(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(c_if.slave));
  mux4_reg #(.WIDTH(16), .REGISTERED(1'b1)) u_wide (.clk(clk), .rst(rst), .bus(w_if.slave));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, d);
    logic [7:0] src [4];
    src = '{a, b, c, d};
    return src[s];
  endfunction

  task automatic tick_check(input string tag, input logic [7:0] exp);
    @(posedge clk);
    #1;
    check(tag, {8'h00, m_if.Aout}, {8'h00, exp});
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] cs [4];
    m_if.alu_out = 8'o1; m_if.Bin = 8'o2; m_if.Cin = 8'o3; m_if.Din = 8'o4;
    m_if.reg_sel4 = 2'd0;
    w_if.alu_out = 16'h1111; w_if.Bin = 16'h2222; w_if.Cin = 16'h3333; w_if.Din = 16'h4444;
    w_if.reg_sel4 = 2'd0;
    c_if.alu_out = 8'o1; c_if.Bin = 8'o2; c_if.Cin = 8'o3; c_if.Din = 8'o4;
    c_if.reg_sel4 = 2'd0;
    rst = 1'b1;
    m_if.reg_sel4 = 2'd2;
    tick_check("reset_edge1", 8'h00);
    tick_check("reset_edge2", 8'h00);
    rst = 1'b0;
    m_if.reg_sel4 = 2'd0;
    tick_check("release_sel0", 8'o1);
    for (int s = 1; s < 4; s++) begin
      m_if.reg_sel4 = 2'(s);
      tick_check($sformatf("sweep_sel%0d", s), 8'(s + 1));
    end
    m_if.reg_sel4 = 2'd2; m_if.Cin = 8'h03;
    tick_check("selC_03", 8'h03);
    m_if.Cin = 8'hA5;
    tick_check("selC_A5", 8'hA5);
    m_if.Bin = 8'h77;
    tick_check("unselected_B", 8'hA5);
    m_if.reg_sel4 = 2'd0; m_if.alu_out = 8'h5C;
    tick_check("sel_and_src_change", 8'h5C);
    m_if.reg_sel4 = 2'd3; m_if.Din = 8'hFF;
    tick_check("selD_FF", 8'hFF);
    rst = 1'b1;
    tick_check("midrun_reset", 8'h00);
    rst = 1'b0;
    tick_check("after_reset_FF", 8'hFF);
    tick_check("steady_FF", 8'hFF);
    w_if.reg_sel4 = 2'd1;
    @(posedge clk); #1;
    check("wide_sel1", w_if.Aout, 16'h2222);
    w_if.reg_sel4 = 2'd3;
    @(posedge clk); #1;
    check("wide_sel3", w_if.Aout, 16'h4444);
    rst = 1'b1;
    cs = '{8'o1, 8'o2, 8'o3, 8'o4};
    for (int s = 0; s < 4; s++) begin
      c_if.reg_sel4 = 2'(s);
      #1;
      check($sformatf("comb_sel%0d", s), {8'h00, c_if.Aout}, {8'h00, cs[s]});
    end
    c_if.Din = 8'h3C;
    #1;
    check("comb_src_change", {8'h00, c_if.Aout}, 16'h003C);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      m_if.alu_out = 8'($urandom); m_if.Bin = 8'($urandom);
      m_if.Cin = 8'($urandom);     m_if.Din = 8'($urandom);
      m_if.reg_sel4 = 2'($urandom);
      c_if.alu_out = 8'($urandom); c_if.Bin = 8'($urandom);
      c_if.Cin = 8'($urandom);     c_if.Din = 8'($urandom);
      c_if.reg_sel4 = 2'($urandom);
      #1;
      check("rand_comb", {8'h00, c_if.Aout},
            {8'h00, pick(c_if.reg_sel4, c_if.alu_out, c_if.Bin, c_if.Cin, c_if.Din)});
      e = rst ? 8'h00 : pick(m_if.reg_sel4, m_if.alu_out, m_if.Bin, m_if.Cin, m_if.Din);
      tick_check("rand_reg", e);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
